// File: rtl/pc_sequencer.sv
// pc_sequencer: next-fetch-address controller with sequential, branch, jump, call/return
// sources, a small hardware return-address stack, stall and halt.
module pc_sequencer #(
    parameter int ADDR_W      = 12,
    parameter int STEP        = 4,
    parameter int RESET_ADDR  = 0,
    parameter int STACK_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           halt,
    input  logic                           resume,
    input  logic                           stall,
    input  logic                           branch_taken,
    input  logic [ADDR_W-1:0]              branch_offset,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic [ADDR_W-1:0]              target_addr,
    output logic [ADDR_W-1:0]              pc,
    output logic                           pc_valid,
    output logic [$clog2(STACK_DEPTH):0]   stack_count,
    output logic                           err_overflow,
    output logic                           err_underflow
);
    localparam int CW = $clog2(STACK_DEPTH) + 1;
    localparam int IW = $clog2(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(RESET_ADDR);
    localparam logic [CW-1:0]     FULL   = CW'(STACK_DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                valid_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, unf_q;
    logic [ADDR_W-1:0]   stk_q [STACK_DEPTH];

    logic adv, do_jump, do_call, do_ret, do_br, full, empty, push, pop;
    logic [ADDR_W-1:0] seq_pc, top;

    // Requests only act in RUN when neither halt nor stall holds the pc.
    assign adv     = (state_q == RUN) && !halt && !stall;
    assign do_jump = adv && jump;
    assign do_call = adv && !jump && call;
    assign do_ret  = adv && !jump && !call && ret;
    assign do_br   = adv && !jump && !call && !ret && branch_taken;
    assign full    = cnt_q == FULL;
    assign empty   = cnt_q == '0;
    assign push    = do_call && !full;
    assign pop     = do_ret && !empty;
    assign seq_pc  = pc_q + STEP_A;
    assign top     = stk_q[IW'(cnt_q - CW'(1))];

    always_comb begin
        pc_d    = !adv ? pc_q :
                  (do_jump || do_call) ? target_addr :
                  do_ret ? (empty ? seq_pc : top) :
                  do_br ? pc_q + branch_offset : seq_pc;
        state_d = state_q == BOOT ? RUN :
                  state_q == RUN  ? (halt ? HALT : RUN) :
                  (resume ? RUN : HALT);
        cnt_d   = push ? cnt_q + CW'(1) : pop ? cnt_q - CW'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RST_A;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= state_d == RUN;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_q | (do_call && full);
            unf_q   <= unf_q | (do_ret && empty);
        end
    end

    // Stack contents need no reset; push is gated by RUN so reset aborts it.
    always_ff @(posedge clk) begin
        if (push) stk_q[IW'(cnt_q)] <= seq_pc;
    end

    assign pc            = pc_q;
    assign pc_valid      = valid_q;
    assign stack_count   = cnt_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan steps plus randomized traffic checked against a
// queue-based reference model of the sequencer.
module tb_pc_sequencer;
    logic        clk = 0, reset = 0;
    logic        halt = 0, resume = 0, stall = 0, branch_taken = 0, jump = 0, call = 0, ret = 0;
    logic [11:0] branch_offset = 0, target_addr = 0;
    logic [11:0] pc;
    logic        pc_valid, err_overflow, err_underflow;
    logic [2:0]  stack_count;

    int n_tests = 0, n_fail = 0;
    int m_mode;          // 0 boot, 1 run, 2 halt
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .halt(halt), .resume(resume), .stall(stall),
        .branch_taken(branch_taken), .branch_offset(branch_offset), .jump(jump),
        .call(call), .ret(ret), .target_addr(target_addr), .pc(pc), .pc_valid(pc_valid),
        .stack_count(stack_count), .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = 0; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    endfunction

    function automatic void model_step();
        if (!reset) begin model_reset(); return; end
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 2) begin if (resume) m_mode = 1; end
        else if (halt) m_mode = 2;
        else if (stall) ;
        else if (jump) m_pc = target_addr;
        else if (call) begin
            if (m_stk.size() < 4) m_stk.push_back((m_pc + 4) % 4096);
            else m_ovf = 1;
            m_pc = target_addr;
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_unf = 1; m_pc = (m_pc + 4) % 4096; end
        end else if (branch_taken) m_pc = (m_pc + branch_offset) % 4096;
        else m_pc = (m_pc + 4) % 4096;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_valid"}, pc_valid, m_mode == 1);
        chk({tag, "_cnt"}, stack_count, m_stk.size());
        chk({tag, "_ovf"}, err_overflow, m_ovf);
        chk({tag, "_unf"}, err_underflow, m_unf);
    endtask

    task automatic req(input logic h, r, s, b, input logic [11:0] off,
                       input logic j, c, rt, input logic [11:0] tgt);
        halt = h; resume = r; stall = s; branch_taken = b; branch_offset = off;
        jump = j; call = c; ret = rt; target_addr = tgt;
    endtask

    task automatic idle(); req(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    // Called at posedge+1: pulses reset low around the falling edge.
    task automatic async_pulse(input string tag);
        #4 reset = 0;
        #1;
        model_reset();
        check_model(tag);
        #1 reset = 1;
    endtask

    initial begin
        model_reset();
        idle();
        repeat (3) tick("in_rst");
        reset = 1;
        #1;
        chk("boot_pc", pc, 12'h000);
        chk("boot_valid", pc_valid, 1'b0);
        // 1: boot then sequential
        tick("t1a"); chk("t1_run_pc", pc, 12'h000); chk("t1_run_valid", pc_valid, 1'b1);
        tick("t1b"); chk("t1_pc4", pc, 12'h004);
        tick("t1c"); chk("t1_pc8", pc, 12'h008);
        tick("t1d"); chk("t1_pcC", pc, 12'h00C);
        tick("t1e"); chk("t1_pc10", pc, 12'h010);
        // 2: call / return
        req(0, 0, 0, 0, 0, 0, 1, 0, 12'h200);
        tick("t2call"); chk("t2_pc200", pc, 12'h200); chk("t2_cnt1", stack_count, 3'd1);
        idle(); tick("t2a"); tick("t2b"); chk("t2_pc208", pc, 12'h208);
        req(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick("t2ret"); chk("t2_pc014", pc, 12'h014); chk("t2_cnt0", stack_count, 3'd0);
        idle(); repeat (3) tick("t3pre"); chk("t3_pc020", pc, 12'h020);
        // 3: priority and stall
        req(0, 0, 0, 1, 12'h010, 1, 1, 0, 12'h100);
        tick("t3pri"); chk("t3_pc100", pc, 12'h100); chk("t3_cnt", stack_count, 3'd0);
        req(0, 0, 1, 1, 12'h010, 1, 1, 1, 12'h300);
        repeat (3) tick("t3stall");
        chk("t3_stall_pc", pc, 12'h100);
        // 4: overflow and underflow
        for (int i = 0; i < 5; i++) begin
            req(0, 0, 0, 0, 0, 0, 1, 0, 12'(12'h300 + 16 * i));
            tick("t4call");
        end
        chk("t4_ovf", err_overflow, 1'b1); chk("t4_cnt4", stack_count, 3'd4);
        req(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) tick("t4ret");
        chk("t4_unf", err_underflow, 1'b1); chk("t4_unf_pc", pc, 12'h108);
        // 5: wrap
        req(0, 0, 0, 0, 0, 1, 0, 0, 12'hFFC); tick("t5j");
        idle(); tick("t5w"); chk("t5_wrap", pc, 12'h000);
        req(0, 0, 0, 0, 0, 1, 0, 0, 12'h002); tick("t5j2");
        req(0, 0, 0, 1, 12'hFFC, 0, 0, 0, 0); tick("t5b"); chk("t5_brwrap", pc, 12'hFFE);
        // 6: halt / resume
        req(0, 0, 0, 0, 0, 1, 0, 0, 12'h040); tick("t6j");
        req(1, 0, 0, 1, 12'h020, 0, 1, 0, 12'h500); tick("t6h");
        chk("t6_halt_valid", pc_valid, 1'b0); chk("t6_halt_pc", pc, 12'h040);
        req(0, 0, 0, 1, 12'h020, 0, 1, 0, 12'h500); repeat (2) tick("t6hold");
        chk("t6_hold_pc", pc, 12'h040); chk("t6_hold_cnt", stack_count, 3'd0);
        req(0, 1, 0, 0, 0, 0, 0, 0, 0); tick("t6res");
        chk("t6_res_valid", pc_valid, 1'b1); chk("t6_res_pc", pc, 12'h040);
        idle(); tick("t6n"); chk("t6_pc044", pc, 12'h044);
        // async reset with two entries stacked and a call pending
        req(0, 0, 0, 0, 0, 0, 1, 0, 12'h600); tick("t6c1"); tick("t6c2");
        chk("t6_cnt2", stack_count, 3'd2);
        async_pulse("t6rst");
        chk("t6_rst_pc", pc, 12'h000); chk("t6_rst_cnt", stack_count, 3'd0);
        chk("t6_rst_flags", {err_overflow, err_underflow}, 2'b00);
        chk("t6_boot_valid", pc_valid, 1'b0);
        tick("t6boot"); chk("t6_boot_pc", pc, 12'h000); chk("t6_boot_cnt", stack_count, 3'd0);
        idle(); tick("t6seq"); chk("t6_seq_pc", pc, 12'h004);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            req(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0), 12'($urandom),
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0), 12'($urandom));
            if ($urandom_range(0, 99) == 0) async_pulse("rnd_rst");
            tick("rnd");
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-address controller for the 12-bit program counter datapath. Each cycle it selects the next fetch address from one of these sources:
- sequential increment
- relative branch
- absolute jump
- call (with push of the return address)
- return (from a small hardware return-address stack)
It also handles stall and halt. It sits between instruction decode and instruction memory and drives the fetch address plus a valid flag.

Parameters:
ADDR_W, 12, width of the program address.
STEP, 4, sequential increment added to pc each advancing cycle.
RESET_ADDR, 0, address loaded on reset.
STACK_DEPTH, 4, number of return-stack entries (power of two, 2..16).

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-low reset.
halt  input  1  request to enter HALT state.
resume  input  1  leave HALT state.
stall  input  1  hold pc for this cycle.
branch_taken  input  1  relative branch request.
branch_offset  input  ADDR_W  two's-complement offset added to pc.
jump  input  1  absolute jump request.
call  input  1  call request: push return address, then go to target_addr.
ret  input  1  return request: pop the stack into pc.
target_addr  input  ADDR_W  destination for jump and call.
pc  output  ADDR_W  current fetch address (registered).
pc_valid  output  1  pc holds a fetchable address this cycle.
stack_count  output  $clog2(STACK_DEPTH)+1  number of occupied stack entries.
err_overflow  output  1  sticky flag: call attempted while the stack is full.
err_underflow  output  1  sticky flag: ret attempted while the stack is empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_ADDR, pc_valid=0, stack_count=0, both error flags 0, state=BOOT.
  - Stack contents are don't-care.
  - Reset asserted mid-operation aborts everything immediately, including a pending push or pop.
- States: BOOT, RUN, HALT.
  - BOOT: exactly one cycle after reset release. pc is held and pc_valid=0, then the block goes to RUN. All request inputs are ignored in BOOT.
  - RUN: pc_valid=1. The next pc is chosen by fixed priority, highest first:
    1. halt: go to HALT, pc held.
    2. stall: pc held, no stack change.
    3. jump: pc<=target_addr.
    4. call: push (pc+STEP), then pc<=target_addr.
    5. ret: pop, pc<=top of stack.
    6. branch_taken: pc<=pc+branch_offset.
    7. none of the above: pc<=pc+STEP.
  - HALT: pc_valid=0, pc held, all requests except resume ignored. resume=1 returns to RUN on the next cycle with pc unchanged; the first RUN cycle re-presents the held pc.
- Latency: one cycle from a request to the new pc appearing on the output. Requests are sampled only in RUN.
- Simultaneous requests: only the highest-priority request takes effect; lower ones are discarded, not queued.
- Arithmetic: all pc arithmetic is modulo 2^ADDR_W, with silent wrap. Examples: pc=0xFFC with STEP=4 gives 0x000; pc=0x002 with offset 0xFFC (-4) gives 0xFFE.
- Stack is a LIFO with STACK_DEPTH entries; stack_count tracks occupancy (0..STACK_DEPTH).
  - Overflow: call when stack_count==STACK_DEPTH. No push, count unchanged, the jump to target_addr still occurs, err_overflow<=1.
  - Underflow: ret when stack_count==0. No pop, pc<=pc+STEP, err_underflow<=1.
  - Error flags clear only on reset.
- stall and halt both block stack operations for that cycle.

Test Plan:
1. Reset release with no requests, sampled on successive cycles → BOOT cycle shows pc=0x000 with pc_valid=0; next cycle pc=0x000 with pc_valid=1; then pc=0x004, 0x008, 0x00C.
2. At pc=0x010: call with target_addr=0x200; then 2 plain cycles; then ret → pc=0x200, 0x204, 0x208, 0x014; stack_count goes 1 then back to 0.
3. jump, call and branch_taken all asserted at pc=0x020 with target_addr=0x100 → pc=0x100 (jump wins) and stack_count unchanged. Then stall for 3 cycles → pc stays 0x100.
4. Five calls, one per cycle, with STACK_DEPTH=4 → err_overflow=1 after the fifth and stack_count=4. Then five rets → fifth ret sets err_underflow=1, and pc = the value before it +4.
5. Wrap: jump to 0xFFC then one plain cycle → pc=0x000. At pc=0x002, branch_taken with offset 0xFFC → pc=0xFFE.
6. Mid-operation checks:
   - halt at pc=0x040 → pc_valid=0 and pc stays 0x040 while branch and call requests are ignored; resume → pc_valid=1 with pc=0x040, then 0x044.
   - Asynchronous reset pulse between clock edges while stack_count=2 → pc=0x000, stack_count=0, flags 0, and BOOT restarts.
